// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: ALU opcodes, instruction field layout,
// register file geometry and the opcode legality check.
package decode_stage_pkg;

    localparam int NUM_REGS   = 8;
    localparam int REG_W      = 8;
    localparam int REG_ADDR_W = 3;
    localparam int INSTR_W    = 16;
    localparam int CTRL_W     = 4;

    localparam int I_FLAG_BIT = 15;
    localparam int CTRL_MSB   = 14;
    localparam int CTRL_LSB   = 11;
    localparam int RD_MSB     = 10;
    localparam int RD_LSB     = 8;
    localparam int RS1_MSB    = 7;
    localparam int RS1_LSB    = 5;
    localparam int RS2_MSB    = 4;
    localparam int RS2_LSB    = 2;
    localparam int IMM_MSB    = 7;
    localparam int IMM_LSB    = 0;

    typedef enum logic [CTRL_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_ctrl_e;

    function automatic logic is_legal_ctrl(input logic [CTRL_W-1:0] code);
        case (code)
            ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
            ALU_SRL, ALU_OR, ALU_AND, ALU_SUB, ALU_SRA: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 8-entry register file: two asynchronous read ports with same-cycle writeback
// bypass, one write port, r0 hardwired to zero.
module regfile8x8
    import decode_stage_pkg::*;
#(
    parameter int DATA_W = REG_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0]     rd1,
    output logic [DATA_W-1:0]     rd2,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0]     wd
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic [REG_ADDR_W-1:0] ra,
        input logic                  wen,
        input logic [REG_ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0]     wdata,
        input logic [DATA_W-1:0]     stored
    );
        if (ra == '0) begin
            return '0;
        end else if (wen && waddr == ra) begin
            return wdata;
        end else begin
            return stored;
        end
    endfunction

    assign rd1 = read_port(ra1, we, wa, wd, mem[ra1]);
    assign rd2 = read_port(ra2, we, wa, wd, mem[ra2]);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: splits the instruction word, reads operands, tracks pending
// destinations on a per-register scoreboard and issues one operation per cycle.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INSTR_W-1:0]    in_instr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [REG_W-1:0]      wb_data,
    output logic [REG_W-1:0]      out_d1,
    output logic [REG_W-1:0]      out_d2,
    output logic [CTRL_W-1:0]     out_control,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  illegal
);

    logic                  i_flag;
    logic [CTRL_W-1:0]     ctrl;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_W-1:0]      imm;
    logic [REG_W-1:0]      rdata1;
    logic [REG_W-1:0]      rdata2;
    logic [REG_W-1:0]      opnd2;
    logic                  legal;
    logic                  hazard;
    logic                  accept;
    logic [NUM_REGS-1:0]   pend_nxt;

    logic [NUM_REGS-1:0]   pend_p1;
    logic                  vld_p1;
    logic                  ill_p1;
    logic [REG_W-1:0]      d1_p1;
    logic [REG_W-1:0]      d2_p1;
    logic [CTRL_W-1:0]     ctrl_p1;
    logic [REG_ADDR_W-1:0] rd_p1;

    // I-type reuses rd as its only source and carries the raw immediate in d2
    assign i_flag = in_instr[I_FLAG_BIT];
    assign ctrl   = in_instr[CTRL_MSB:CTRL_LSB];
    assign rd     = in_instr[RD_MSB:RD_LSB];
    assign rs1    = i_flag ? rd : in_instr[RS1_MSB:RS1_LSB];
    assign rs2    = in_instr[RS2_MSB:RS2_LSB];
    assign imm    = in_instr[IMM_MSB:IMM_LSB];
    assign legal  = is_legal_ctrl(ctrl);
    assign opnd2  = i_flag ? imm : rdata2;

    regfile8x8 #(
        .DATA_W (REG_W)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (rs1),
        .ra2   (rs2),
        .rd1   (rdata1),
        .rd2   (rdata2),
        .we    (wb_en),
        .wa    (wb_addr),
        .wd    (wb_data)
    );

    // A source is free again in the very cycle its writeback arrives (bypass)
    function automatic logic src_busy(
        input logic [NUM_REGS-1:0]   pend,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  wen,
        input logic [REG_ADDR_W-1:0] waddr
    );
        return pend[src] && !(wen && waddr == src);
    endfunction

    assign hazard   = src_busy(pend_p1, rs1, wb_en, wb_addr) ||
                      (!i_flag && src_busy(pend_p1, rs2, wb_en, wb_addr));
    assign in_ready = (!vld_p1 || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    // Clear first, then set, so a new claim on a register wins over its writeback
    always_comb begin
        pend_nxt = pend_p1;
        if (wb_en) begin
            pend_nxt[wb_addr] = 1'b0;
        end
        if (accept && legal && rd != '0) begin
            pend_nxt[rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // ---- stage p1: issued operation register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_p1 <= '0;
            vld_p1  <= 1'b0;
            ill_p1  <= 1'b0;
            d1_p1   <= '0;
            d2_p1   <= '0;
            ctrl_p1 <= '0;
            rd_p1   <= '0;
        end else begin
            pend_p1 <= pend_nxt;
            ill_p1  <= accept && !legal;
            if (accept && legal) begin
                vld_p1  <= 1'b1;
                d1_p1   <= rdata1;
                d2_p1   <= opnd2;
                ctrl_p1 <= ctrl;
                rd_p1   <= rd;
            end else if (out_ready) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign out_valid   = vld_p1;
    assign illegal     = ill_p1;
    assign out_d1      = d1_p1;
    assign out_d2      = d2_p1;
    assign out_control = ctrl_p1;
    assign out_rd      = rd_p1;

endmodule
